periph_responder: RTL and testbench

- Memory-mapped peripheral responder on the CPU data-memory bus. Same signal set as the data memory: MemRead, MemWrite, Address, Write_data, Read_data.
- Decodes a fixed address window and contains:
  - a reloadable 32-bit timer with interrupt;
  - LED and 7-segment output registers;
  - a free-running system tick counter.
- Sits beside the data memory in the MEM stage. The CPU selects this block's read data when `hit` is 1.

---
 rtl/periph_pkg.sv | 24 ++
 rtl/periph_responder_if.sv | 22 ++
 rtl/periph_timer.sv | 63 ++++++
 rtl/periph_responder.sv | 102 ++++++++++
 tb/tb_periph_responder.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/periph_pkg.sv
// Shared constants for the memory-mapped peripheral responder:
// register byte offsets, TCON bit indices and the default window base.
package periph_pkg;

  localparam logic [31:0] BASE_DEFAULT = 32'h4000_0000;

  localparam logic [4:0] OFS_TH      = 5'h00;
  localparam logic [4:0] OFS_TL      = 5'h04;
  localparam logic [4:0] OFS_TCON    = 5'h08;
  localparam logic [4:0] OFS_LED     = 5'h0C;
  localparam logic [4:0] OFS_DIGI    = 5'h10;
  localparam logic [4:0] OFS_SYSTICK = 5'h14;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IS = 2;

  typedef struct packed {
    logic th;
    logic tl;
    logic tcon;
  } tmr_we_t;

endpackage

// File: rtl/periph_responder_if.sv
// Data-memory style bus between the MEM stage and the peripheral
// responder; the CPU side is master, the responder is slave.
interface periph_responder_if;

  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic [31:0] Read_data;
  logic        hit;

  modport master (
    output MemRead, MemWrite, Address, Write_data,
    input  Read_data, hit
  );

  modport slave (
    input  MemRead, MemWrite, Address, Write_data,
    output Read_data, hit
  );

endinterface

// File: rtl/periph_timer.sv
// Reloadable 32-bit timer: prescaler, TH/TL/TCON and the irq status
// bit, where a hardware set beats a same-cycle software clear.
module periph_timer
  import periph_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  tmr_we_t     we,
  input  logic [31:0] wdata,
  output logic [31:0] th,
  output logic [31:0] tl,
  output logic [2:0]  tcon,
  output logic        irq
);

  localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

  logic [15:0] pcnt;
  logic        tick;
  logic        wrap;
  logic        ovf;
  logic        sw_keep;

  assign tick = tcon[TCON_EN] && (pcnt == PS_LAST);
  assign wrap = (tl == 32'hFFFF_FFFF);
  // A CPU write to TL on a tick suppresses both increment and overflow.
  assign ovf  = tick && wrap && !we.tl;
  assign sw_keep = !(we.tcon && !wdata[TCON_IS]);
  assign irq  = tcon[TCON_IS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt <= '0;
      th   <= '0;
      tl   <= '0;
      tcon <= '0;
    end else begin
      if (!tcon[TCON_EN] || tick)
        pcnt <= '0;
      else
        pcnt <= pcnt + 16'd1;

      if (we.th)
        th <= wdata;

      if (we.tl)
        tl <= wdata;
      else if (tick)
        tl <= wrap ? th : tl + 32'd1;

      if (we.tcon) begin
        tcon[TCON_EN] <= wdata[TCON_EN];
        tcon[TCON_IE] <= wdata[TCON_IE];
      end

      tcon[TCON_IS] <= (ovf && tcon[TCON_IE])
                    || (tcon[TCON_IS] && sw_keep);
    end
  end

endmodule

// File: rtl/periph_responder.sv
// Peripheral responder beside the data memory: timer, LED, 7-segment
// and SYSTICK. SYSTICK flops exist only with PERIPH_SYSTICK_EN defined.
module periph_responder
  import periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = BASE_DEFAULT,
  parameter int          PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        reset,
  periph_responder_if.slave bus,
  output logic        irq,
  output logic [7:0]  led,
  output logic [11:0] digi
);

  logic [4:0]  ofs;
  logic        wr;
  logic        sel_th;
  logic        sel_tl;
  logic        sel_tcon;
  logic        sel_led;
  logic        sel_digi;
  logic        sel_sys;
  logic [31:0] th;
  logic [31:0] tl;
  logic [2:0]  tcon;
  logic [31:0] systick;
  logic [31:0] rmux;
  tmr_we_t     twe;
  logic        unused_addr;

  assign unused_addr = ^bus.Address[1:0];

  assign bus.hit = (bus.Address[31:5] == BASE_ADDR[31:5]);
  assign ofs     = {bus.Address[4:2], 2'b00};
  assign wr      = bus.MemWrite && bus.hit;

  assign sel_th   = (ofs == OFS_TH);
  assign sel_tl   = (ofs == OFS_TL);
  assign sel_tcon = (ofs == OFS_TCON);
  assign sel_led  = (ofs == OFS_LED);
  assign sel_digi = (ofs == OFS_DIGI);
  assign sel_sys  = (ofs == OFS_SYSTICK);

  assign twe.th   = wr && sel_th;
  assign twe.tl   = wr && sel_tl;
  assign twe.tcon = wr && sel_tcon;

  periph_timer #(
    .PRESCALE (PRESCALE)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .we    (twe),
    .wdata (bus.Write_data),
    .th    (th),
    .tl    (tl),
    .tcon  (tcon),
    .irq   (irq)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led  <= '0;
      digi <= '0;
    end else begin
      if (wr && sel_led)
        led <= bus.Write_data[7:0];
      if (wr && sel_digi)
        digi <= bus.Write_data[11:0];
    end
  end

`ifdef PERIPH_SYSTICK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      systick <= '0;
    else
      systick <= systick + 32'd1;
  end
`else
  assign systick = '0;
`endif

  // Reserved offsets fall through to the zero default.
  always_comb begin
    rmux = '0;
    unique case (1'b1)
      sel_th:   rmux = th;
      sel_tl:   rmux = tl;
      sel_tcon: rmux = {29'b0, tcon};
      sel_led:  rmux = {24'b0, led};
      sel_digi: rmux = {20'b0, digi};
      sel_sys:  rmux = systick;
      default:  rmux = '0;
    endcase
  end

  assign bus.Read_data = (bus.MemRead && bus.hit) ? rmux : 32'h0;

endmodule

// File: tb/tb_periph_responder.sv
// Bench for periph_responder: two instances (PRESCALE 1 and 3) on one
// stimulus stream, checked every cycle against a behavioural model.
module tb_periph_responder;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  periph_responder_if b1 ();
  periph_responder_if b3 ();

  assign b3.MemRead    = b1.MemRead;
  assign b3.MemWrite   = b1.MemWrite;
  assign b3.Address    = b1.Address;
  assign b3.Write_data = b1.Write_data;

  logic        irq1, irq3;
  logic [7:0]  led1, led3;
  logic [11:0] digi1, digi3;

  periph_responder #(.BASE_ADDR(BASE), .PRESCALE(1)) dut1 (
    .clk(clk), .reset(reset), .bus(b1.slave),
    .irq(irq1), .led(led1), .digi(digi1)
  );

  periph_responder #(.BASE_ADDR(BASE), .PRESCALE(3)) dut3 (
    .clk(clk), .reset(reset), .bus(b3.slave),
    .irq(irq3), .led(led3), .digi(digi3)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_th [2] = '{0, 0};
  logic [31:0] m_tl [2] = '{0, 0};
  logic [2:0]  m_tcon [2] = '{0, 0};
  int          m_pc [2] = '{0, 0};
  logic [7:0]  m_led = 0;
  logic [11:0] m_digi = 0;
  logic [31:0] m_sys = 0;

  function automatic int psv(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic bit in_win(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'd32);
  endfunction

  function automatic int widx(input logic [31:0] a);
    logic [31:0] d;
    d = (a - BASE) / 4;
    return int'(d[2:0]);
  endfunction

  function automatic logic [31:0] m_read(input int k, input int idx);
    case (idx)
      0: return m_th[k];
      1: return m_tl[k];
      2: return {29'b0, m_tcon[k]};
      3: return {24'b0, m_led};
      4: return {20'b0, m_digi};
`ifdef PERIPH_SYSTICK_EN
      5: return m_sys;
`endif
      default: return 32'h0;
    endcase
  endfunction

  bit          mw, mt, nis, wtl;
  int          mi;
  logic [31:0] md;

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        m_th[k] = 0; m_tl[k] = 0; m_tcon[k] = 0; m_pc[k] = 0;
      end
      m_led = 0; m_digi = 0; m_sys = 0;
    end else begin
      mw = b1.MemWrite && in_win(b1.Address);
      mi = widx(b1.Address);
      md = b1.Write_data;
      wtl = mw && (mi == 1);
      for (int k = 0; k < 2; k++) begin
        mt = m_tcon[k][0] && ((m_pc[k] % psv(k)) == psv(k) - 1);
        nis = m_tcon[k][2];
        if (mw && mi == 2 && !md[2]) nis = 0;
        if (mt && !wtl && m_tl[k] == 32'hFFFF_FFFF && m_tcon[k][1]) nis = 1;
        m_pc[k] = m_tcon[k][0] ? m_pc[k] + 1 : 0;
        if (wtl) m_tl[k] = md;
        else if (mt) m_tl[k] = (m_tl[k] == 32'hFFFF_FFFF) ? m_th[k] : m_tl[k] + 1;
        if (mw && mi == 0) m_th[k] = md;
        if (mw && mi == 2) m_tcon[k][1:0] = md[1:0];
        m_tcon[k][2] = nis;
      end
      if (mw && mi == 3) m_led = md[7:0];
      if (mw && mi == 4) m_digi = md[11:0];
      m_sys = m_sys + 1;
    end
  end

  task automatic cmp(input int k);
    logic [31:0] rdv, exp;
    logic h, q;
    logic [7:0] l;
    logic [11:0] dg;
    if (k == 0) begin
      rdv = b1.Read_data; h = b1.hit; q = irq1; l = led1; dg = digi1;
    end else begin
      rdv = b3.Read_data; h = b3.hit; q = irq3; l = led3; dg = digi3;
    end
    exp = (b1.MemRead && in_win(b1.Address)) ? m_read(k, widx(b1.Address)) : 32'h0;
    chk($sformatf("m_hit%0d", k), {31'b0, h}, {31'b0, in_win(b1.Address)});
    chk($sformatf("m_rd%0d", k), rdv, exp);
    chk($sformatf("m_irq%0d", k), {31'b0, q}, {31'b0, m_tcon[k][2]});
    chk($sformatf("m_led%0d", k), {24'b0, l}, {24'b0, m_led});
    chk($sformatf("m_digi%0d", k), {20'b0, dg}, {20'b0, m_digi});
  endtask

  initial forever begin
    @(negedge clk);
    cmp(0);
    cmp(1);
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    b1.MemWrite = 1'b1;
    b1.Address = a;
    b1.Write_data = d;
    @(posedge clk);
    #1;
    b1.MemWrite = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d1,
                    output logic [31:0] d3, output logic h);
    b1.MemRead = 1'b1;
    b1.Address = a;
    #1;
    d1 = b1.Read_data;
    d3 = b3.Read_data;
    h = b1.hit;
    @(negedge clk);
    #1;
    b1.MemRead = 1'b0;
  endtask

  logic [31:0] r1, r3, s1;
  logic        h;

  initial begin
    b1.MemRead = 0;
    b1.MemWrite = 0;
    b1.Address = 0;
    b1.Write_data = 0;

    cyc(1);
    for (int i = 0; i < 8; i++) begin
      rd(BASE + 32'(i * 4), r1, r3, h);
      chk($sformatf("rst_rd_%0d", i), r1, 32'h0);
    end
    @(posedge clk);
    #3;
    reset = 1'b1;
    cyc(1);

    // reload and irq
    wr(BASE + 32'h00, 32'hFFFF_FFFC);
    wr(BASE + 32'h04, 32'hFFFF_FFFE);
    wr(BASE + 32'h08, 32'h3);
    cyc(2);
    rd(BASE + 32'h04, r1, r3, h);
    chk("reload_tl1", r1, 32'hFFFF_FFFC);
    chk("reload_tl3", r3, 32'hFFFF_FFFE);
    chk("reload_irq1", {31'b0, irq1}, 32'h1);
    chk("reload_irq3", {31'b0, irq3}, 32'h0);
    cyc(4);
    rd(BASE + 32'h04, r1, r3, h);
    chk("period_tl1", r1, 32'hFFFF_FFFC);
    chk("period_tl3", r3, 32'hFFFF_FFFC);
    chk("period_irq3", {31'b0, irq3}, 32'h1);

    // clear on an overflow edge (dut1) and a quiet edge (dut3)
    cyc(3);
    wr(BASE + 32'h08, 32'h3);
    chk("race_irq1", {31'b0, irq1}, 32'h1);
    chk("race_irq3", {31'b0, irq3}, 32'h0);
    wr(BASE + 32'h08, 32'h3);
    chk("clear_irq1", {31'b0, irq1}, 32'h0);

    // prescaler
    wr(BASE + 32'h08, 32'h0);
    wr(BASE + 32'h04, 32'h0);
    wr(BASE + 32'h08, 32'h1);
    cyc(3);
    rd(BASE + 32'h04, r1, r3, h);
    chk("ps_tl3_a", r3, 32'd1);
    chk("ps_tl1_a", r1, 32'd3);
    cyc(3);
    rd(BASE + 32'h04, r1, r3, h);
    chk("ps_tl3_b", r3, 32'd2);
    chk("ps_tl1_b", r1, 32'd6);
    wr(BASE + 32'h08, 32'h0);
    cyc(5);
    rd(BASE + 32'h04, r1, r3, h);
    chk("freeze_tl3", r3, 32'd2);
    chk("freeze_tl1", r1, 32'd7);
    wr(BASE + 32'h08, 32'h1);
    cyc(2);
    rd(BASE + 32'h04, r1, r3, h);
    chk("restart_tl3_a", r3, 32'd2);
    cyc(1);
    rd(BASE + 32'h04, r1, r3, h);
    chk("restart_tl3_b", r3, 32'd3);
    chk("restart_tl1_b", r1, 32'd10);

    // decode, led, digi, reserved
    wr(BASE + 32'h0C, 32'h0000_01A5);
    chk("led_val", {24'b0, led1}, 32'hA5);
    rd(BASE + 32'h0C, r1, r3, h);
    chk("led_rd", r1, 32'h0000_00A5);
    wr(32'h1000_000C, 32'h0000_005A);
    chk("led_miss", {24'b0, led1}, 32'hA5);
    rd(32'h1000_000C, r1, r3, h);
    chk("miss_rd", r1, 32'h0);
    chk("miss_hit", {31'b0, h}, 32'h0);
    wr(BASE + 32'h10, 32'hFFFF_F123);
    chk("digi_val", {20'b0, digi1}, 32'h123);
    rd(BASE + 32'h10, r1, r3, h);
    chk("digi_rd", r1, 32'h123);
    wr(BASE + 32'h18, 32'hDEAD_BEEF);
    rd(BASE + 32'h18, r1, r3, h);
    chk("rsv18", r1, 32'h0);
    rd(BASE + 32'h00, r1, r3, h);
    chk("th_rd", r1, 32'hFFFF_FFFC);
    rd(BASE + 32'h08, r1, r3, h);
    chk("tcon_rd", r1, 32'h1);

    // systick
    rd(BASE + 32'h14, s1, r3, h);
    chk("sys_hit", {31'b0, h}, 32'h1);
    cyc(10);
    rd(BASE + 32'h14, r1, r3, h);
`ifdef PERIPH_SYSTICK_EN
    chk("sys_delta", r1 - s1, 32'd10);
`else
    chk("sys_zero", r1, 32'h0);
`endif

    // reset mid-count with irq pending
    wr(BASE + 32'h08, 32'h2);
    wr(BASE + 32'h04, 32'hFFFF_FFFF);
    wr(BASE + 32'h08, 32'h3);
    cyc(1);
    chk("pre_rst_irq1", {31'b0, irq1}, 32'h1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("rst_irq1", {31'b0, irq1}, 32'h0);
    chk("rst_led", {24'b0, led1}, 32'h0);
    chk("rst_digi", {20'b0, digi1}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      rd(BASE + 32'(i * 4), r1, r3, h);
      chk($sformatf("mid_rst_rd_%0d", i), r1, 32'h0);
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
    cyc(3);
    rd(BASE + 32'h14, r1, r3, h);
`ifdef PERIPH_SYSTICK_EN
    chk("sys_after_rst", r1, 32'd3);
`else
    chk("sys_after_rst", r1, 32'd0);
`endif
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
